// File: rtl/clic_pkg.sv
// Shared types for the CLIC arbiter: candidate record, FSM states and the priority-key helpers.
package clic_pkg;

  // Candidate IDs are carried at a fixed width so the tree is reusable across source counts.
  localparam int unsigned ClicIdMaxW = 16;
  localparam int unsigned ClicKeyW   = 2 + 8 + ClicIdMaxW;

  typedef logic [1:0] priv_lvl_t;

  localparam priv_lvl_t PrivU = 2'b00;
  localparam priv_lvl_t PrivS = 2'b01;
  localparam priv_lvl_t PrivM = 2'b11;

  typedef struct packed {
    logic                  valid;
    logic [ClicIdMaxW-1:0] id;
    logic [7:0]            level;
    priv_lvl_t             priv;
  } clic_cand_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_PRESENT,
    ARB_KILL,
    ARB_DRAIN
  } clic_arb_state_e;

  // Inverted ID makes the lower ID win ties on privilege and level.
  function automatic logic [ClicKeyW-1:0] clic_key(input clic_cand_t c);
    return {c.priv, c.level, ~c.id};
  endfunction

  // True when a is valid and strictly better than b (any valid beats an invalid b).
  function automatic logic clic_beats(input clic_cand_t a, input clic_cand_t b);
    return a.valid & (~b.valid | (clic_key(a) > clic_key(b)));
  endfunction

endpackage

// File: rtl/clic_max_tree.sv
// Combinational binary max-tree selecting the best eligible source (ip & ie) by {priv, level, ~id}.
// Laid out as a heap: leaves at the bottom, one comparator per internal node, root at index 0.
module clic_max_tree
  import clic_pkg::*;
#(
  parameter int unsigned NumSrc = 256
) (
  input  logic      [NumSrc-1:0]      i_ip,
  input  logic      [NumSrc-1:0]      i_ie,
  input  logic      [NumSrc-1:0][7:0] i_level,
  input  priv_lvl_t [NumSrc-1:0]      i_priv,
  output clic_cand_t                  o_best
);

  localparam int unsigned Levels   = $clog2(NumSrc);
  localparam int unsigned NumLeaf  = 1 << Levels;
  localparam int unsigned HeapSize = 2 * NumLeaf - 1;

  clic_cand_t w_heap [HeapSize];

  always_comb begin
    for (int unsigned n = 0; n < HeapSize; n++) begin
      w_heap[n] = '0;
    end
    for (int unsigned i = 0; i < NumSrc; i++) begin
      w_heap[NumLeaf - 1 + i].valid = i_ip[i] & i_ie[i];
      w_heap[NumLeaf - 1 + i].id    = ClicIdMaxW'(i);
      w_heap[NumLeaf - 1 + i].level = i_level[i];
      w_heap[NumLeaf - 1 + i].priv  = i_priv[i];
    end
    // Children always sit at higher indices, so a descending sweep sees them already resolved.
    for (int n = int'(NumLeaf) - 2; n >= 0; n--) begin
      w_heap[n] = clic_beats(w_heap[2*n+2], w_heap[2*n+1]) ? w_heap[2*n+2] : w_heap[2*n+1];
    end
  end

  assign o_best = w_heap[0];

endmodule

// File: rtl/cva6_clic_arbiter.sv
// CLIC arbiter: registers the best pending source, presents it over valid/ready, and withdraws it
// via the kill handshake when a strictly better candidate appears or the source is retracted.
module cva6_clic_arbiter
  import clic_pkg::*;
#(
  parameter int unsigned NumSrc  = 256,
  parameter int unsigned IdWidth = $clog2(NumSrc)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NumSrc-1:0]         ip_i,
  input  logic [NumSrc-1:0]         ie_i,
  input  logic [NumSrc-1:0][7:0]    level_i,
  input  logic [NumSrc-1:0][1:0]    priv_i,
  output logic                      irq_valid_o,
  output logic [IdWidth-1:0]        irq_id_o,
  output logic [7:0]                irq_level_o,
  output logic [1:0]                irq_priv_o,
  input  logic                      irq_ready_i,
  output logic                      kill_req_o,
  input  logic                      kill_ack_i,
  output logic                      claim_valid_o,
  output logic [IdWidth-1:0]        claim_id_o
);

  clic_cand_t      w_best;
  clic_cand_t      w_pres;
  logic            w_pres_live;
  logic            w_preempt;

  clic_cand_t      r_cand;
  clic_arb_state_e r_state;
  logic            r_irq_valid;
  logic [IdWidth-1:0] r_irq_id;
  logic [7:0]      r_irq_level;
  priv_lvl_t       r_irq_priv;
  logic            r_kill_req;
  logic            r_claim_valid;
  logic [IdWidth-1:0] r_claim_id;

  clic_max_tree #(
    .NumSrc (NumSrc)
  ) u_max_tree (
    .i_ip    (ip_i),
    .i_ie    (ie_i),
    .i_level (level_i),
    .i_priv  (priv_i),
    .o_best  (w_best)
  );

  // The presented interrupt as a candidate, so it can be ranked against cand_q with the same key.
  assign w_pres = '{valid: 1'b1,
                    id:    ClicIdMaxW'(r_irq_id),
                    level: r_irq_level,
                    priv:  r_irq_priv};

  assign w_pres_live = ip_i[r_irq_id] & ie_i[r_irq_id];
  assign w_preempt   = clic_beats(r_cand, w_pres);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_cand        <= '0;
      r_state       <= ARB_IDLE;
      r_irq_valid   <= 1'b0;
      r_irq_id      <= '0;
      r_irq_level   <= '0;
      r_irq_priv    <= '0;
      r_kill_req    <= 1'b0;
      r_claim_valid <= 1'b0;
      r_claim_id    <= '0;
    end else begin
      r_cand        <= w_best;
      r_claim_valid <= 1'b0;
      unique case (r_state)
        ARB_IDLE: begin
          if (r_cand.valid) begin
            r_irq_valid <= 1'b1;
            r_irq_id    <= r_cand.id[IdWidth-1:0];
            r_irq_level <= r_cand.level;
            r_irq_priv  <= r_cand.priv;
            r_state     <= ARB_PRESENT;
          end
        end
        ARB_PRESENT: begin
          if (irq_ready_i) begin
            r_claim_valid <= 1'b1;
            r_claim_id    <= r_irq_id;
            r_irq_valid   <= 1'b0;
            r_state       <= ARB_DRAIN;
          end else if (w_preempt || !w_pres_live) begin
            r_kill_req <= 1'b1;
            r_state    <= ARB_KILL;
          end
        end
        ARB_KILL: begin
          // Acceptance beats withdrawal: the core has already taken the interrupt.
          if (irq_ready_i) begin
            r_claim_valid <= 1'b1;
            r_claim_id    <= r_irq_id;
            r_irq_valid   <= 1'b0;
            r_kill_req    <= 1'b0;
            r_state       <= ARB_DRAIN;
          end else if (kill_ack_i) begin
            r_irq_valid <= 1'b0;
            r_kill_req  <= 1'b0;
            r_state     <= ARB_DRAIN;
          end
        end
        ARB_DRAIN: begin
          // cand_q was sampled before the claimed pending bit could clear; skip it once.
          r_state <= ARB_IDLE;
        end
        default: begin
          r_state <= ARB_IDLE;
        end
      endcase
    end
  end

  assign irq_valid_o   = r_irq_valid;
  assign irq_id_o      = r_irq_id;
  assign irq_level_o   = r_irq_level;
  assign irq_priv_o    = r_irq_priv;
  assign kill_req_o    = r_kill_req;
  assign claim_valid_o = r_claim_valid;
  assign claim_id_o    = r_claim_id;

  a_claim_one_cycle: assert property (@(posedge clk_i) claim_valid_o |=> !claim_valid_o);
  a_kill_needs_valid: assert property (@(posedge clk_i) kill_req_o |-> irq_valid_o);

endmodule

// File: doc/cva6_clic_arbiter.md
# cva6_clic_arbiter

CLIC-side interrupt arbiter that selects the highest-priority pending, enabled source among `NumSrc` inputs and presents it to the core-side CLIC controller over the valid/ready interrupt handshake. It owns the kill handshake: it withdraws a presented interrupt when a strictly better candidate appears or the presented source is retracted. It also emits a one-cycle claim pulse so edge-triggered pending bits can be cleared. It sits between the CLIC register file (pending/enable/level/priv per source) and the core's `clic_irq_*` inputs.

## Interface
- `NumSrc`, 256, number of interrupt sources (≥2)
- `IdWidth`, `$clog2(NumSrc)`, source ID width
- `clk_i`  in  1  clock
- `rst_ni`  in  1  reset; one clock, synchronous, active-low
- `ip_i`  in  NumSrc  pending bits
- `ie_i`  in  NumSrc  enable bits
- `level_i`  in  NumSrc×8  per-source level
- `priv_i`  in  NumSrc×2  per-source privilege (`riscv::priv_lvl_t`)
- `irq_valid_o`  out  1  interrupt presented
- `irq_id_o`  out  IdWidth  presented ID
- `irq_level_o`  out  8  presented level
- `irq_priv_o`  out  2  presented privilege
- `irq_ready_i`  in  1  core accepted (acknowledged) presented interrupt
- `kill_req_o`  out  1  request to withdraw presented interrupt
- `kill_ack_i`  in  1  core permits withdrawal
- `claim_valid_o`  out  1  one-cycle pulse on acceptance
- `claim_id_o`  out  IdWidth  accepted ID

## Operation
- Eligible source i: `ip_i[i] & ie_i[i]`.
- Priority key: `{priv, level, ~id}`, compared as unsigned, 2+8+IdWidth bits. Higher privilege wins, then higher level, then lower ID. Level 0 is eligible; threshold filtering is the core's job.
- Stage 1 is a combinational max-tree over eligible sources, registered into `cand_q` = {valid, id, level, priv}.
- FSM states:
  - **IDLE**: `irq_valid_o`=0. If `cand_q.valid`, latch `cand_q` into the output registers and go to PRESENT.
  - **PRESENT**: `irq_valid_o`=1; ID, level and priv are held stable.
    - If `irq_ready_i`, pulse claim with `irq_id_o` and go to DRAIN.
    - Otherwise, if `cand_q.valid` and `cand_q` key > presented key (strict), or `ip_i[irq_id_o] & ie_i[irq_id_o]`==0, go to KILL.
  - **KILL**: `irq_valid_o`=1 and `kill_req_o`=1; outputs are held.
    - If `irq_ready_i`, pulse claim and go to DRAIN. Ready wins, including when `kill_ack_i` is asserted in the same cycle.
    - Otherwise, if `kill_ack_i`, go to DRAIN with no claim.
    - Further better candidates arriving in KILL do not re-enter KILL and do not change outputs.
  - **DRAIN**: `irq_valid_o`=0 and `kill_req_o`=0. Ignore `cand_q`, which was sampled before the claim clear, for one cycle, then go to IDLE.
- A retracted-then-reasserted source in KILL still completes the kill handshake; there is no abort.
- `kill_ack_i` outside KILL is ignored. `irq_ready_i` outside PRESENT/KILL is ignored.
- Level-triggered sources still pending after DRAIN are re-arbitrated normally.

## Timing
- Reset values: `irq_valid_o`=0, `kill_req_o`=0, `claim_valid_o`=0, `irq_id_o`/`irq_level_o`/`irq_priv_o`/`claim_id_o`=0, FSM=IDLE, `cand_q.valid`=0.
- Latency: eligibility visible in cycle N gives `cand_q` at N+1 and `irq_valid_o` at N+2 when the FSM is in IDLE.
- Claim pulse is asserted exactly 1 cycle, in the cycle after the `irq_ready_i` sample, aligned with DRAIN entry.
- Kill: a better candidate in `cand_q` at cycle N asserts `kill_req_o` from N+1.
- `kill_req_o` deasserts in the cycle after `kill_ack_i` or `irq_ready_i` is sampled.
- Minimum gap between two presentations: 2 idle cycles (DRAIN, IDLE).
- Reset asserted mid-handshake: all outputs return to reset values the next cycle. No claim pulse is emitted for the aborted interrupt.

## Structure
- Shared package `clic_pkg`: `clic_cand_t` struct {valid, id, level, priv} and `clic_arb_state_e` {IDLE, PRESENT, KILL, DRAIN}.
- Sub-module `clic_max_tree`: parametric binary compare tree over `clic_cand_t`. It is purely combinational, uses log2(NumSrc) levels, and is reusable for other source counts.
- The top level holds the `cand_q` register, FSM, output registers and claim logic.

## Test plan
- Single source: id 5, M-mode, level 0x40 pending at cycle 0 → `irq_valid_o`=1 at cycle 2 with id 5/0x40/M. Ready at cycle 4 → claim pulse id 5 at cycle 5, valid=0 at cycle 5.
- Priority ordering:
  - ids 3 (S, 0xFF) and 9 (M, 0x01) pending → id 9 presented.
  - ids 7 and 4 both M with level 0x80 → id 4 presented.
- Preemption: id 2 (M, 0x10) presented; id 6 (M, 0x20) becomes pending → `kill_req_o` 2 cycles later. `kill_ack_i` → valid drops, no claim, id 6 presented 2 cycles after DRAIN.
- Simultaneous ready and `kill_ack_i` in KILL → claim pulse for the presented ID, `kill_req_o` drops, DRAIN entered.
- Retraction: presented id 11 has `ie_i` cleared → `kill_req_o` next cycle. No claim after `kill_ack_i`.
- Synchronous reset asserted in KILL → next cycle all outputs 0, FSM IDLE. After deassert with id 1 pending, id 1 is presented 2 cycles later.
